// File: rtl/axi_master_bridge_if.sv
// Bundle of the core-side request/response port and the AXI4 master channels
// handled by axi_master_bridge. The bridge uses the master view.
interface axi_master_bridge_if #(
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    // core request / response
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [7:0]        req_len;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              rsp_err;

    // AXI read address / data
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    // AXI write address / data / response
    logic [3:0]        awid;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_len, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_len, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_master_bridge.sv
// Core memory port to AXI4 master: one read burst (1-256 beats) or one
// single-beat write per request, with a single transaction outstanding.
module axi_master_bridge #(
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_master_bridge_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic              aw_done;
    logic              w_done;
    logic              arvalid_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_hs = arvalid_q & bus.arready;
    assign r_hs  = (state == R) & bus.rvalid & bus.rsp_ready;
    assign aw_hs = awvalid_q & bus.awready;
    assign w_hs  = wvalid_q & bus.wready;
    assign b_hs  = (state == B) & bus.bvalid & bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        len_q   <= bus.req_len;
                        wdata_q <= bus.req_wdata;
                        wstrb_q <= bus.req_wstrb;
                        if (bus.req_wen) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= AWW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= AR;
                        end
                    end
                end
                AR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= R;
                    end
                end
                R: begin
                    // Only rlast ends the burst; a short or long burst is flagged, not truncated.
                    if (r_hs) begin
                        cnt <= cnt + 8'd1;
                        if (bus.rlast) state <= IDLE;
                    end
                end
                AWW: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= B;
                    end
                end
                B: begin
                    if (b_hs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_last  = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rready    = 1'b0;
        bus.bready    = 1'b0;
        case (state)
            R: begin
                bus.rsp_valid = bus.rvalid;
                bus.rready    = bus.rsp_ready;
                bus.rsp_rdata = bus.rdata;
                bus.rsp_last  = bus.rlast;
                bus.rsp_err   = (bus.rresp != 2'b00) | (bus.rlast != (cnt == len_q));
            end
            B: begin
                bus.rsp_valid = bus.bvalid;
                bus.bready    = bus.rsp_ready;
                bus.rsp_last  = 1'b1;
                bus.rsp_err   = (bus.bresp != 2'b00);
            end
            default: ;
        endcase
    end

    assign bus.arid    = 4'd0;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = len_q;
    assign bus.arsize  = 3'd3;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = arvalid_q;

    assign bus.awid    = 4'd0;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = 3'd3;
    assign bus.awburst = 2'b01;
    assign bus.awvalid = awvalid_q;

    assign bus.wid     = 4'd0;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: directed cases plus randomized reads/writes
// checked cycle by cycle against a transaction-level model of the bridge.
module tb_axi_master_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_master_bridge_if #(.DATA_W(64)) bus ();
    axi_master_bridge #(.DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic send_req(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                            input logic [63:0] wd, input logic [7:0] ws);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        @(negedge clk);
        chk("req_ready", 128'(bus.req_ready), 128'(1'b1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_len   = 8'($urandom);
        bus.req_wdata = {$urandom, $urandom};
        bus.req_wstrb = 8'($urandom);
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input int last_idx,
                            input logic [63:0] base, input int err_beat, input logic [1:0] err_resp,
                            input int ar_dly, input int rdy_mode, input bit rv_rand,
                            input int abort_after);
        int cyc;
        int i;
        bit done;
        bit hs;
        logic exp_err;
        send_req(1'b0, addr, len, {$urandom, $urandom}, 8'($urandom));
        cyc = 0; done = 0;
        while (!done && cyc < 64) begin
            bus.arready = (cyc >= ar_dly);
            @(negedge clk);
            chk("ar_ctl", 128'({bus.arvalid, bus.req_ready, bus.rsp_valid, bus.rready,
                                bus.awvalid, bus.wvalid}), 128'(6'b100000));
            chk("ar_bus", 128'({bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid}),
                          128'({addr, len, 3'd3, 2'b01, 4'd0}));
            hs = bus.arready;
            @(posedge clk); #1;
            cyc++;
            if (hs) done = 1;
        end
        bus.arready = 1'b0;
        if (!done) chk("ar_timeout", 128'(1'b0), 128'(1'b1));

        i = 0; cyc = 0; done = 0;
        while (!done && cyc < 600) begin
            bus.rvalid    = rv_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.rdata     = base + 64'(i);
            bus.rresp     = (i == err_beat) ? err_resp : 2'b00;
            bus.rlast     = (i == last_idx);
            bus.rsp_ready = ready_for(rdy_mode, cyc);
            @(negedge clk);
            chk("r_ctl", 128'({bus.rsp_valid, bus.rready, bus.arvalid, bus.req_ready}),
                         128'({bus.rvalid, bus.rsp_ready, 1'b0, 1'b0}));
            if (bus.rvalid) begin
                exp_err = (bus.rresp != 2'b00) || ((i == last_idx) != (i == int'(len)));
                chk("r_beat", 128'({bus.rsp_rdata, bus.rsp_last, bus.rsp_err}),
                              128'({base + 64'(i), (i == last_idx), exp_err}));
            end
            hs = bus.rvalid && bus.rsp_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                if (i == last_idx) done = 1;
                i++;
                if (abort_after > 0 && i == abort_after) break;
            end
        end
        bus.rlast = 1'b0;

        if (abort_after > 0) begin
            // slave keeps rvalid up to show the dropped burst no longer reaches the core
            bus.rvalid    = 1'b1;
            bus.rsp_ready = 1'b1;
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_flush", 128'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                                   bus.rsp_valid, bus.req_ready}), 128'(7'b0000000));
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_release", 128'({bus.req_ready, bus.rsp_valid, bus.rready}), 128'(3'b100));
            @(posedge clk); #1;
            bus.rvalid = 1'b0;
        end else begin
            bus.rvalid = 1'b0;
            if (!done) chk("r_timeout", 128'(1'b0), 128'(1'b1));
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] bresp, input int rdy_mode);
        int cyc;
        bit awd, wd, aw_hs, w_hs, done, hs;
        send_req(1'b1, addr, 8'($urandom), data, strb);
        awd = 0; wd = 0; cyc = 0;
        while (!(awd && wd) && cyc < 64) begin
            bus.awready = (cyc >= aw_dly);
            bus.wready  = (cyc >= w_dly);
            @(negedge clk);
            chk("aww_ctl", 128'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rsp_valid, bus.req_ready}),
                           128'({!awd, !wd, 3'b000}));
            if (!awd)
                chk("aw_bus", 128'({bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid}),
                              128'({addr, 8'd0, 3'd3, 2'b01, 4'd0}));
            if (!wd)
                chk("w_bus", 128'({bus.wdata, bus.wstrb, bus.wlast, bus.wid}),
                             128'({data, strb, 1'b1, 4'd0}));
            aw_hs = !awd && bus.awready;
            w_hs  = !wd && bus.wready;
            @(posedge clk); #1;
            awd = awd | aw_hs;
            wd  = wd | w_hs;
            cyc++;
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        if (!(awd && wd)) chk("aww_timeout", 128'(1'b0), 128'(1'b1));

        cyc = 0; done = 0;
        while (!done && cyc < 64) begin
            bus.bvalid    = (cyc >= b_dly);
            bus.bresp     = bresp;
            bus.rsp_ready = ready_for(rdy_mode, cyc);
            @(negedge clk);
            chk("b_ctl", 128'({bus.rsp_valid, bus.bready, bus.awvalid, bus.wvalid, bus.req_ready}),
                         128'({bus.bvalid, bus.rsp_ready, 3'b000}));
            if (bus.bvalid)
                chk("b_rsp", 128'({bus.rsp_rdata, bus.rsp_last, bus.rsp_err}),
                             128'({64'd0, 1'b1, (bresp != 2'b00)}));
            hs = bus.bvalid && bus.rsp_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) done = 1;
        end
        bus.bvalid = 1'b0;
        if (!done) chk("b_timeout", 128'(1'b0), 128'(1'b1));
    endtask

    initial begin
        int len;
        int last;
        int eb;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0; bus.rsp_ready = 1'b0;
        bus.arready = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
        bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bid = '0; bus.bresp = '0; bus.bvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ctl", 128'({bus.req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                             bus.bready, bus.rsp_valid}), 128'(7'b0));
        chk("rst_bus", 128'({bus.araddr, bus.awaddr, bus.wstrb}), 128'(0));
        chk("rst_wdata", 128'(bus.wdata), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_read(32'h8000_0000, 8'd0, 0, 64'h1122334455667788, -1, 2'b00, 0, 0, 1'b0, 0);
        run_read(32'h0000_1000, 8'd3, 3, {$urandom, $urandom}, -1, 2'b00, 0, 1, 1'b0, 0);
        run_write(32'h0000_2000, 64'hDEADBEEF_00000000, 8'hF0, 3, 0, 0, 2'b00, 0);
        run_write(32'h0000_2008, {$urandom, $urandom}, 8'hFF, 0, 0, 0, 2'b10, 0);
        run_read(32'h0000_3000, 8'd1, 1, {$urandom, $urandom}, 1, 2'b11, 0, 0, 1'b0, 0);
        run_read(32'h0000_4000, 8'd3, 1, {$urandom, $urandom}, -1, 2'b00, 0, 0, 1'b0, 0);
        run_read(32'h0000_5000, 8'd1, 3, {$urandom, $urandom}, -1, 2'b00, 1, 0, 1'b0, 0);
        run_write(32'h0000_5008, {$urandom, $urandom}, 8'h0F, 0, 2, 1, 2'b00, 1);
        run_read(32'h0000_6000, 8'd3, 3, {$urandom, $urandom}, -1, 2'b00, 0, 0, 1'b0, 1);
        run_read(32'h0000_7000, 8'd3, 3, {$urandom, $urandom}, -1, 2'b00, 0, 0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                run_write($urandom & 32'hFFFF_FFF8, {$urandom, $urandom}, 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 2);
            end else begin
                len  = $urandom_range(0, 7);
                case ($urandom_range(0, 5))
                    0:       last = (len > 0) ? len - 1 : len;
                    1:       last = len + 1;
                    default: last = len;
                endcase
                eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
                run_read($urandom & 32'hFFFF_FFF8, 8'(len), last, {$urandom, $urandom}, eb,
                         2'($urandom_range(1, 3)), $urandom_range(0, 3), 2, 1'b1, 0);
            end
        end

        @(negedge clk);
        chk("idle_end", 128'({bus.req_ready, bus.arvalid, bus.awvalid, bus.wvalid}), 128'(4'b1000));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
